// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the E stage: sequences MULT/MULTU/DIV/DIVU with a fixed
// countdown latency and applies MTHI/MTLO writes immediately.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic        op_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);

    // One 64-bit multiplier serves both flavours: sign- or zero-extension
    // makes the truncated product correct for signed and unsigned operands.
    ext_a   = {{32{op_signed & a[31]}}, a};
    ext_b   = {{32{op_signed & b[31]}}, b};
    product = ext_a * ext_b;

    // Signed division done on magnitudes, then sign-corrected. The
    // 0x80000000 / -1 case falls out naturally as lo=0x80000000, hi=0.
    a_neg    = op_signed & a[31];
    b_neg    = op_signed & b[31];
    mag_a    = a_neg ? (32'd0 - a) : a;
    mag_b    = b_neg ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    safe_b   = div_zero ? 32'd1 : mag_b;
    q_mag    = mag_a / safe_b;
    r_mag    = mag_a % safe_b;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the pending result registers are reset too, so an aborted
    // operation can never leak into hi/lo after reset.
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      // Commands arriving while busy are dropped; the countdown owns the block.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy    <= 1'b0;
        pend_wr <= 1'b0;
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          pend_hi <= product[63:32];
          pend_lo <= product[31:0];
          pend_wr <= 1'b1;
          cnt     <= CNT_W'(MULT_CYCLES);
          busy    <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero still costs the full latency but commits nothing.
          pend_hi <= rem;
          pend_lo <= quot;
          pend_wr <= ~div_zero;
          cnt     <= CNT_W'(DIV_CYCLES);
          busy    <= 1'b1;
        end
        OP_MTHI: hi <= a;
        OP_MTLO: lo <= a;
        OP_NONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a completion-time reference model checked
// every cycle, plus literal expectations for the key arithmetic cases.
module tb_muldiv_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  muldiv_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op finishes at edge number done_at; the
  // block is busy strictly before that edge and commits exactly on it.
  int          cyc     = 0;
  int          done_at = 0;
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  logic        m_wr;
  logic        exp_busy;
  longint      sa, sb;
  logic [63:0] prod;
  int          ia, ib;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_wr = 1'b0; done_at = 0;
    end else if (cyc < done_at) begin
      // busy: command ignored
    end else if (cyc == done_at) begin
      if (m_wr) begin m_hi = m_ph; m_lo = m_pl; end
    end else if (start) begin
      case (md_op)
        OP_MULT: begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          prod = 64'(sa * sb);
          m_ph = prod[63:32]; m_pl = prod[31:0]; m_wr = 1'b1;
          done_at = cyc + MULT_CYCLES;
        end
        OP_MULTU: begin
          prod = {32'd0, a} * {32'd0, b};
          m_ph = prod[63:32]; m_pl = prod[31:0]; m_wr = 1'b1;
          done_at = cyc + MULT_CYCLES;
        end
        OP_DIV: begin
          ia = a; ib = b;
          if (b == 32'd0) m_wr = 1'b0;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_pl = 32'h8000_0000; m_ph = 32'd0; m_wr = 1'b1;
          end else begin
            m_pl = ia / ib; m_ph = ia % ib; m_wr = 1'b1;
          end
          done_at = cyc + DIV_CYCLES;
        end
        OP_DIVU: begin
          if (b == 32'd0) m_wr = 1'b0;
          else begin m_pl = a / b; m_ph = a % b; m_wr = 1'b1; end
          done_at = cyc + DIV_CYCLES;
        end
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        default: ;
      endcase
    end
    exp_busy = (cyc < done_at);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, exp_busy});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; md_op = op; a = va; b = vb;
    tick(1);
    start = 1'b0; md_op = OP_NONE;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; md_op = OP_MULT; a = 32'hFFFF_FFFE; b = 32'd3;
    @(posedge clk); chk_en = 1'b1; #1;
    tick(1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0; start = 1'b0; md_op = OP_NONE;
    tick(1);
    check("start_under_reset_busy", {31'd0, busy}, 32'd0);

    // MULT -2 * 3
    cmd(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_first", {31'd0, busy}, 32'd1);
    check("mult_hi_old", hi, 32'd0);
    tick(4);
    check("mult_busy_last", {31'd0, busy}, 32'd1);
    check("mult_lo_old", lo, 32'd0);
    tick(1);
    check("mult_busy_drop", {31'd0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    cmd(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    tick(5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // Divisions
    cmd(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    tick(9);
    check("div_busy_last", {31'd0, busy}, 32'd1);
    check("div_hi_old", hi, 32'h0000_0002);
    tick(1);
    check("div_busy_drop", {31'd0, busy}, 32'd0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    cmd(OP_DIVU, 32'd7, 32'd2);
    tick(10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    cmd(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(10);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // MTHI then MTLO back to back
    start = 1'b1; md_op = OP_MTHI; a = 32'h1234_5678;
    tick(1);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = OP_MTLO; a = 32'h9ABC_DEF0;
    tick(1);
    start = 1'b0; md_op = OP_NONE;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi, 32'h1234_5678);

    cmd(OP_RSVD, 32'hDEAD_BEEF, 32'd1);
    check("rsvd_hi", hi, 32'h1234_5678);
    cmd(OP_NONE, 32'hDEAD_BEEF, 32'd1);
    check("none_lo", lo, 32'h9ABC_DEF0);

    // Divide by zero: full latency, nothing written
    cmd(OP_DIV, 32'd5, 32'd0);
    check("div0_busy", {31'd0, busy}, 32'd1);
    tick(10);
    check("div0_busy_drop", {31'd0, busy}, 32'd0);
    check("div0_hi", hi, 32'h1234_5678);
    check("div0_lo", lo, 32'h9ABC_DEF0);

    // MULT while busy is dropped; MULT on the cycle busy falls is taken
    cmd(OP_DIV, 32'd100, 32'd7);
    tick(2);
    cmd(OP_MULT, 32'd9, 32'd9);
    tick(6);
    check("ignored_busy_last", {31'd0, busy}, 32'd1);
    tick(1);
    check("ignored_div_lo", lo, 32'd14);
    check("ignored_div_hi", hi, 32'd2);
    cmd(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    tick(4);
    check("b2b_busy_last", {31'd0, busy}, 32'd1);
    tick(1);
    check("b2b_hi", hi, 32'd1);
    check("b2b_lo", lo, 32'd0);

    // Reset in the middle of a division
    cmd(OP_DIV, 32'd9, 32'd2);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick(12);
    check("abort_no_late_hi", hi, 32'd0);
    check("abort_no_late_lo", lo, 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
